// File: rtl/clock_pkg.sv
// Shared definitions for the time-setting front end: field-state encoding,
// FIELD_SEL bit positions, repeat-FSM states and parameter defaults.
package clock_pkg;

    // Field being edited; RUN means normal timekeeping.
    typedef enum logic [2:0] {
        RUN  = 3'd0,
        SEC  = 3'd1,
        MIN  = 3'd2,
        HOUR = 3'd3,
        DAY  = 3'd4,
        MON  = 3'd5,
        YEAR = 3'd6
    } field_t;

    // Auto-repeat generator states.
    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2,
        R_LOCK   = 2'd3
    } rep_state_t;

    // FIELD_SEL bit positions.
    localparam int unsigned SEL_SEC  = 0;
    localparam int unsigned SEL_MIN  = 1;
    localparam int unsigned SEL_HOUR = 2;
    localparam int unsigned SEL_DAY  = 3;
    localparam int unsigned SEL_MON  = 4;
    localparam int unsigned SEL_YEAR = 5;

    // Parameter defaults (kHz ticks unless noted; timeout in 1 Hz ticks).
    localparam int unsigned DEF_REPEAT_DELAY  = 500;
    localparam int unsigned DEF_REPEAT_PERIOD = 100;
    localparam int unsigned DEF_BLINK_HALF    = 250;
    localparam int unsigned DEF_TIMEOUT_S     = 30;

    // One-hot field select for a state; all-zero in RUN.
    function automatic logic [5:0] field_onehot(input field_t f);
        logic [5:0] sel;
        sel = '0;
        case (f)
            SEC:     sel[SEL_SEC]  = 1'b1;
            MIN:     sel[SEL_MIN]  = 1'b1;
            HOUR:    sel[SEL_HOUR] = 1'b1;
            DAY:     sel[SEL_DAY]  = 1'b1;
            MON:     sel[SEL_MON]  = 1'b1;
            YEAR:    sel[SEL_YEAR] = 1'b1;
            default: sel = '0;
        endcase
        return sel;
    endfunction

    // Field that follows f on a btn_next press; YEAR wraps back to RUN.
    function automatic field_t field_after(input field_t f);
        field_t n;
        case (f)
            SEC:     n = MIN;
            MIN:     n = HOUR;
            HOUR:    n = DAY;
            DAY:     n = MON;
            MON:     n = YEAR;
            default: n = RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/inc_repeat.sv
// Auto-repeat generator for the increment button: one pulse on press, a
// second after REPEAT_DELAY kHz ticks, then one every REPEAT_PERIOD ticks.
module inc_repeat
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,          // 1 kHz single-cycle tick
    input  logic edit,          // field FSM is in an edit state
    input  logic inc_level,     // debounced increment button level
    input  logic inc_rise,      // rising edge of inc_level
    input  logic field_change,  // selected field changes this cycle
    output logic pulse_next,    // INC_PULSE will be high next cycle
    output logic inc_pulse
);

    localparam logic [9:0] DELAY_LAST  = 10'(REPEAT_DELAY - 1);
    localparam logic [9:0] PERIOD_LAST = 10'(REPEAT_PERIOD - 1);

    rep_state_t state;
    rep_state_t state_next;
    logic [9:0] tick_cnt;
    logic [9:0] tick_cnt_next;
    logic [9:0] tick_cnt_sat;
    logic       delay_done;
    logic       period_done;

    // Tick counter saturates so long delays never wrap into a false match.
    assign tick_cnt_sat = (tick_cnt == '1) ? tick_cnt : tick_cnt + 10'd1;
    assign delay_done   = tick && (tick_cnt >= DELAY_LAST);
    assign period_done  = tick && (tick_cnt >= PERIOD_LAST);

    // State register, tick counter and registered pulse output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= R_IDLE;
            tick_cnt  <= '0;
            inc_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            inc_pulse <= pulse_next;
        end
    end

    // Next-state logic: release always returns to idle; a field change while
    // held parks in R_LOCK so the new field is not bumped by a stale press.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        if (!inc_level) begin
            state_next    = R_IDLE;
            tick_cnt_next = '0;
        end else if (field_change) begin
            state_next    = R_LOCK;
            tick_cnt_next = '0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (inc_rise && edit) begin
                        state_next    = R_DELAY;
                        tick_cnt_next = '0;
                    end
                end
                R_DELAY: begin
                    if (delay_done) begin
                        state_next    = R_REPEAT;
                        tick_cnt_next = '0;
                    end else if (tick) begin
                        tick_cnt_next = tick_cnt_sat;
                    end
                end
                R_REPEAT: begin
                    if (period_done) begin
                        tick_cnt_next = '0;
                    end else if (tick) begin
                        tick_cnt_next = tick_cnt_sat;
                    end
                end
                default: begin
                    state_next = R_LOCK;
                end
            endcase
        end
    end

    // Pulse request; a pulse in flight blocks another so strobes never abut.
    always_comb begin
        pulse_next = 1'b0;
        if (inc_level && !field_change && !inc_pulse) begin
            case (state)
                R_IDLE:   pulse_next = inc_rise && edit;
                R_DELAY:  pulse_next = delay_done;
                R_REPEAT: pulse_next = period_done;
                default:  pulse_next = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/set_sequencer.sv
// Time-setting sequencer: walks the edited field, generates increment
// strobes with auto-repeat, blinks the selected field and times out to RUN.
module set_sequencer
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned BLINK_HALF    = DEF_BLINK_HALF,
    parameter int unsigned TIMEOUT_S     = DEF_TIMEOUT_S
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE_kHz,
    input  logic       ENABLE,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic       SET_ACTIVE,
    output logic [5:0] FIELD_SEL,
    output logic       INC_PULSE,
    output logic       BLINK,
    output logic       TICK_HOLD
);

    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_S - 1);
    localparam logic [9:0] BLINK_LAST   = 10'(BLINK_HALF - 1);

    field_t     state;
    field_t     state_next;
    logic       edit;
    logic       inc_d;
    logic       inc_rise;
    logic       activity;
    logic       timeout_hit;
    logic       field_change;
    logic [5:0] to_cnt;
    logic [9:0] blink_cnt;
    logic       blink_q;
    logic       pulse_next;

    assign edit     = (state != RUN);
    assign inc_rise = btn_inc && !inc_d;
    assign activity = btn_mode || btn_next || inc_rise;

    // Any button activity in the expiry cycle wins over the timeout.
    assign timeout_hit  = edit && ENABLE && !activity && (to_cnt >= TIMEOUT_LAST);
    assign field_change = btn_mode || (btn_next && edit) || timeout_hit;

    // Field state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Field next-state: mode toggles edit, next walks fields, timeout exits.
    always_comb begin
        state_next = state;
        if (btn_mode) begin
            state_next = edit ? RUN : SEC;
        end else if (timeout_hit) begin
            state_next = RUN;
        end else if (btn_next && edit) begin
            state_next = field_after(state);
        end
    end

    // Field-derived outputs, decoded from the registered state.
    always_comb begin
        SET_ACTIVE = edit;
        FIELD_SEL  = field_onehot(state);
        TICK_HOLD  = (state == SEC);
        BLINK      = blink_q;
    end

    // Increment-button edge register; resets high so a held button is not
    // seen as a fresh press after reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            inc_d <= 1'b1;
        end else begin
            inc_d <= btn_inc;
        end
    end

    // Inactivity timeout counted in 1 Hz ticks while editing.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            to_cnt <= '0;
        end else if (!edit || field_change || activity) begin
            to_cnt <= '0;
        end else if (ENABLE) begin
            to_cnt <= to_cnt + 6'd1;
        end
    end

    // Blink phase: restarts visible on each increment and field change so the
    // operator always sees the value just changed.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            blink_q   <= 1'b1;
            blink_cnt <= '0;
        end else if (!edit || pulse_next || field_change) begin
            blink_q   <= 1'b1;
            blink_cnt <= '0;
        end else if (ENABLE_kHz) begin
            if (blink_cnt >= BLINK_LAST) begin
                blink_q   <= !blink_q;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 10'd1;
            end
        end
    end

    inc_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_inc_repeat (
        .clk         (CLK),
        .rst_n       (RESET),
        .tick        (ENABLE_kHz),
        .edit        (edit),
        .inc_level   (btn_inc),
        .inc_rise    (inc_rise),
        .field_change(field_change),
        .pulse_next  (pulse_next),
        .inc_pulse   (INC_PULSE)
    );

endmodule

// File: tb/tb_set_sequencer.sv
// Self-checking bench for set_sequencer against a behavioural model of the
// field walk, repeat timing, blink phase and inactivity timeout.
module tb_set_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ENABLE_kHz;
    logic       ENABLE;
    logic       btn_mode;
    logic       btn_next;
    logic       btn_inc;
    logic       SET_ACTIVE;
    logic [5:0] FIELD_SEL;
    logic       INC_PULSE;
    logic       BLINK;
    logic       TICK_HOLD;

    int n_checks = 0;
    int n_fail   = 0;
    int ms       = 0;      // kHz ticks since the last timing origin
    int pos      = 0;      // model field position: 0 RUN, 1 SEC .. 6 YEAR
    int idle_s   = 0;      // model seconds since last button activity
    int pulse_log[$];
    int exp_q[$];
    logic prev_pulse = 1'b0;

    always #5 CLK = ~CLK;

    set_sequencer #(
        .REPEAT_DELAY (500),
        .REPEAT_PERIOD(100),
        .BLINK_HALF   (250),
        .TIMEOUT_S    (30)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE_kHz(ENABLE_kHz),
        .ENABLE    (ENABLE),
        .btn_mode  (btn_mode),
        .btn_next  (btn_next),
        .btn_inc   (btn_inc),
        .SET_ACTIVE(SET_ACTIVE),
        .FIELD_SEL (FIELD_SEL),
        .INC_PULSE (INC_PULSE),
        .BLINK     (BLINK),
        .TICK_HOLD (TICK_HOLD)
    );

    // Pulse monitor: logs strobe times and checks the global strobe rules.
    always @(negedge CLK) begin
        if (RESET && INC_PULSE) begin
            pulse_log.push_back(ms);
            n_checks++;
            if (SET_ACTIVE !== 1'b1) begin
                n_fail++;
                $display("FAIL pulse_in_run: SET_ACTIVE=%b during INC_PULSE, required 1", SET_ACTIVE);
            end
            n_checks++;
            if (prev_pulse) begin
                n_fail++;
                $display("FAIL pulse_back_to_back: INC_PULSE high two cycles at ms=%0d, required single cycle", ms);
            end
        end
        prev_pulse = RESET ? INC_PULSE : 1'b0;
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: time limit reached before completion, required finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [5:0] model_sel(input int p);
        logic [5:0] one;
        one = 6'd1;
        return (p == 0) ? 6'd0 : (one << (p - 1));
    endfunction

    // Expected strobe times for a press held for 'hold' kHz ticks.
    function automatic void build_expected(input int hold);
        exp_q.delete();
        exp_q.push_back(0);
        for (int t = 500; t <= hold; t += 100) exp_q.push_back(t);
    endfunction

    task automatic khz_tick();
        @(negedge CLK) ENABLE_kHz = 1'b1;
        @(posedge CLK);
        #1 ENABLE_kHz = 1'b0;
        ms++;
        repeat ($urandom_range(1, 2)) @(negedge CLK);
    endtask

    task automatic hz_tick();
        @(negedge CLK) ENABLE = 1'b1;
        @(negedge CLK) ENABLE = 1'b0;
        if (pos != 0) begin
            idle_s++;
            if (idle_s >= 30) pos = 0;
        end
    endtask

    task automatic press_mode();
        @(negedge CLK) btn_mode = 1'b1;
        @(negedge CLK) btn_mode = 1'b0;
        pos = (pos == 0) ? 1 : 0;
        idle_s = 0;
    endtask

    task automatic press_next();
        @(negedge CLK) btn_next = 1'b1;
        @(negedge CLK) btn_next = 1'b0;
        if (pos != 0) pos = (pos == 6) ? 0 : pos + 1;
        idle_s = 0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; ENABLE_kHz = 1'b0; ENABLE = 1'b0;
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++; if (SET_ACTIVE !== 1'b0) begin n_fail++; $display("FAIL reset_set_active: got %b, required 0", SET_ACTIVE); end
        n_checks++; if (FIELD_SEL !== 6'd0) begin n_fail++; $display("FAIL reset_field_sel: got %b, required 000000", FIELD_SEL); end
        n_checks++; if (INC_PULSE !== 1'b0) begin n_fail++; $display("FAIL reset_inc_pulse: got %b, required 0", INC_PULSE); end
        n_checks++; if (BLINK !== 1'b1) begin n_fail++; $display("FAIL reset_blink: got %b, required 1", BLINK); end
        n_checks++; if (TICK_HOLD !== 1'b0) begin n_fail++; $display("FAIL reset_tick_hold: got %b, required 0", TICK_HOLD); end
        @(negedge CLK) RESET = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++; if (INC_PULSE !== 1'b0) begin n_fail++; $display("FAIL reset_release_pulse: got %b, required 0", INC_PULSE); end
        @(negedge CLK) btn_inc = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_field_walk();
        press_next();
        n_checks++; if (FIELD_SEL !== 6'd0) begin n_fail++; $display("FAIL next_in_run: FIELD_SEL=%b, required 000000", FIELD_SEL); end
        press_mode();
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (FIELD_SEL !== model_sel(pos)) begin n_fail++; $display("FAIL walk_sel_%0d: got %b, required %b", i, FIELD_SEL, model_sel(pos)); end
            n_checks++;
            if (SET_ACTIVE !== (pos != 0)) begin n_fail++; $display("FAIL walk_active_%0d: got %b, required %b", i, SET_ACTIVE, (pos != 0)); end
            n_checks++;
            if (TICK_HOLD !== (pos == 1)) begin n_fail++; $display("FAIL walk_tick_hold_%0d: got %b, required %b", i, TICK_HOLD, (pos == 1)); end
            if (i < 6) press_next();
        end
    endtask

    task automatic test_auto_repeat();
        int hold;
        for (int trial = 0; trial < 4; trial++) begin
            hold = (trial == 0) ? 1000 : int'($urandom_range(0, 800));
            press_mode();
            pulse_log.delete();
            ms = 0;
            @(negedge CLK) btn_inc = 1'b1;
            for (int t = 0; t < hold; t++) begin
                khz_tick();
                n_checks++;
                if (TICK_HOLD !== 1'b1) begin n_fail++; $display("FAIL repeat_tick_hold: got %b at ms=%0d, required 1", TICK_HOLD, ms); end
            end
            @(negedge CLK) btn_inc = 1'b0;
            repeat (150) khz_tick();
            build_expected(hold);
            n_checks++;
            if (pulse_log.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL repeat_count_hold%0d: got %0d pulses, required %0d", hold, pulse_log.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (pulse_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL repeat_time_%0d: pulse at ms=%0d, required ms=%0d", i, pulse_log[i], exp_q[i]); end
                end
            end
            press_mode();
        end
    endtask

    task automatic test_lock();
        press_mode();
        press_next();
        pulse_log.delete();
        @(negedge CLK) btn_inc = 1'b1;
        repeat (10) khz_tick();
        press_next();
        n_checks++; if (FIELD_SEL !== model_sel(pos)) begin n_fail++; $display("FAIL lock_shift: got %b, required %b", FIELD_SEL, model_sel(pos)); end
        repeat (700) khz_tick();
        n_checks++; if (pulse_log.size() !== 1) begin n_fail++; $display("FAIL lock_held_pulses: got %0d, required 1", pulse_log.size()); end
        n_checks++; if (FIELD_SEL !== model_sel(pos)) begin n_fail++; $display("FAIL lock_sel_stable: got %b, required %b", FIELD_SEL, model_sel(pos)); end
        @(negedge CLK) btn_inc = 1'b0;
        repeat (5) khz_tick();
        pulse_log.delete();
        @(negedge CLK) btn_inc = 1'b1;
        repeat (3) khz_tick();
        @(negedge CLK) btn_inc = 1'b0;
        n_checks++; if (pulse_log.size() !== 1) begin n_fail++; $display("FAIL lock_repress: got %0d pulses, required 1", pulse_log.size()); end
        press_mode();
        // Held from RUN into edit mode.
        @(negedge CLK) btn_inc = 1'b1;
        repeat (3) khz_tick();
        pulse_log.delete();
        press_mode();
        repeat (700) khz_tick();
        n_checks++; if (pulse_log.size() !== 0) begin n_fail++; $display("FAIL entry_held_pulses: got %0d, required 0", pulse_log.size()); end
        n_checks++; if (SET_ACTIVE !== 1'b1) begin n_fail++; $display("FAIL entry_held_active: got %b, required 1", SET_ACTIVE); end
        @(negedge CLK) btn_inc = 1'b0;
        press_mode();
    endtask

    task automatic test_timeout();
        press_mode();
        repeat (29) hz_tick();
        n_checks++; if (SET_ACTIVE !== (pos != 0)) begin n_fail++; $display("FAIL timeout_t29: SET_ACTIVE=%b, required %b", SET_ACTIVE, (pos != 0)); end
        hz_tick();
        n_checks++; if (SET_ACTIVE !== (pos != 0)) begin n_fail++; $display("FAIL timeout_t30: SET_ACTIVE=%b, required %b", SET_ACTIVE, (pos != 0)); end
        n_checks++; if (FIELD_SEL !== model_sel(pos)) begin n_fail++; $display("FAIL timeout_sel: got %b, required %b", FIELD_SEL, model_sel(pos)); end
        press_mode();
        repeat (29) hz_tick();
        press_next();
        hz_tick();
        n_checks++; if (FIELD_SEL !== model_sel(pos)) begin n_fail++; $display("FAIL timeout_restart: got %b, required %b", FIELD_SEL, model_sel(pos)); end
        repeat (28) hz_tick();
        n_checks++; if (SET_ACTIVE !== (pos != 0)) begin n_fail++; $display("FAIL timeout_restart_29: SET_ACTIVE=%b, required %b", SET_ACTIVE, (pos != 0)); end
        hz_tick();
        n_checks++; if (SET_ACTIVE !== (pos != 0)) begin n_fail++; $display("FAIL timeout_restart_30: SET_ACTIVE=%b, required %b", SET_ACTIVE, (pos != 0)); end
    endtask

    task automatic test_mode_next_same();
        press_mode();
        press_next();
        n_checks++; if (FIELD_SEL !== 6'b000010) begin n_fail++; $display("FAIL both_pre: got %b, required 000010", FIELD_SEL); end
        @(negedge CLK) begin btn_mode = 1'b1; btn_next = 1'b1; end
        @(negedge CLK) begin btn_mode = 1'b0; btn_next = 1'b0; end
        pos = 0;
        n_checks++; if (FIELD_SEL !== 6'd0) begin n_fail++; $display("FAIL both_sel: got %b, required 000000", FIELD_SEL); end
        n_checks++; if (SET_ACTIVE !== 1'b0) begin n_fail++; $display("FAIL both_active: got %b, required 0", SET_ACTIVE); end
    endtask

    task automatic test_blink();
        int ph;
        int n;
        logic exp_b;
        press_mode();
        ph = 0;
        n = $urandom_range(260, 480);
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < ((k == 0) ? n : 300); t++) begin
                khz_tick();
                ph++;
                exp_b = ((ph / 250) % 2) == 0;
                n_checks++;
                if (BLINK !== exp_b) begin n_fail++; $display("FAIL blink_phase_%0d: got %b after %0d ticks, required %b", k, BLINK, ph, exp_b); end
            end
            if (k == 0) begin
                @(negedge CLK) btn_inc = 1'b1;
                @(negedge CLK) btn_inc = 1'b0;
                n_checks++; if (INC_PULSE !== 1'b1) begin n_fail++; $display("FAIL blink_inc_pulse: got %b, required 1", INC_PULSE); end
            end else if (k == 1) begin
                press_next();
            end
            if (k < 2) begin
                ph = 0;
                n_checks++; if (BLINK !== 1'b1) begin n_fail++; $display("FAIL blink_forced_%0d: got %b, required 1", k, BLINK); end
            end
        end
        press_mode();
        while (pos != 0) press_next();
        n_checks++; if (BLINK !== 1'b1) begin n_fail++; $display("FAIL blink_run: got %b, required 1", BLINK); end
    endtask

    task automatic test_reset_mid_repeat();
        press_mode();
        ms = 0;
        @(negedge CLK) btn_inc = 1'b1;
        repeat (599) khz_tick();
        @(negedge CLK) ENABLE_kHz = 1'b1;
        @(posedge CLK);
        #1 ENABLE_kHz = 1'b0;
        ms++;
        n_checks++; if (INC_PULSE !== 1'b1) begin n_fail++; $display("FAIL mid_repeat_pulse600: got %b, required 1", INC_PULSE); end
        #1 RESET = 1'b0;
        #1;
        pos = 0;
        n_checks++; if (INC_PULSE !== 1'b0) begin n_fail++; $display("FAIL async_inc_pulse: got %b, required 0", INC_PULSE); end
        n_checks++; if (SET_ACTIVE !== 1'b0) begin n_fail++; $display("FAIL async_active: got %b, required 0", SET_ACTIVE); end
        n_checks++; if (FIELD_SEL !== 6'd0) begin n_fail++; $display("FAIL async_sel: got %b, required 000000", FIELD_SEL); end
        n_checks++; if (BLINK !== 1'b1) begin n_fail++; $display("FAIL async_blink: got %b, required 1", BLINK); end
        n_checks++; if (TICK_HOLD !== 1'b0) begin n_fail++; $display("FAIL async_tick_hold: got %b, required 0", TICK_HOLD); end
        repeat (3) @(negedge CLK);
        @(negedge CLK) RESET = 1'b1;
        pulse_log.delete();
        repeat (700) khz_tick();
        n_checks++; if (pulse_log.size() !== 0) begin n_fail++; $display("FAIL post_reset_pulses: got %0d, required 0", pulse_log.size()); end
        @(negedge CLK) btn_inc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_field_walk();
        test_auto_repeat();
        test_lock();
        test_timeout();
        test_mode_next_same();
        test_blink();
        test_reset_mid_repeat();
        repeat (5) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
